// File: rtl/frame_serializer_if.sv
// Parallel frame input handshake between a frame source and the serializer.
interface frame_serializer_if;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/frame_serializer.sv
// 3-bit frame serializer: 2-entry FIFO feeding a free-running 3-phase shifter.
// Idle 000 frames fill the stream whenever the FIFO is empty at a frame boundary.
module frame_serializer #(
    parameter bit REJECT_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    frame_serializer_if.slave        in_if,
    output logic                     dout,
    output logic                     frame_start,
    output logic                     rej,
    output logic [7:0]               frame_cnt
);
    typedef enum logic [1:0] {P0, P1, P2} phase_e;

    phase_e     state_q, state_d;
    logic [2:0] fr_q, fr_d;
    logic [2:0] mem_q [2];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] occ_q, occ_d;
    logic       rej_q, rej_d;
    logic [7:0] cnt_q, cnt_d;

    logic fire;
    logic illegal;
    logic push;
    logic pop;

    assign in_if.in_ready = (occ_q < 2'd2);
    assign fire    = in_if.in_valid && in_if.in_ready;
    assign illegal = REJECT_ILLEGAL && (in_if.in_data == 3'b111);
    assign push    = fire && !illegal;
    // No bypass: a frame pushed this edge is never visible to pop.
    assign pop     = (state_q == P2) && (occ_q != 2'd0);

    always_comb begin
        state_d     = state_q;
        fr_d        = fr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_q;
        rej_d       = fire && illegal;
        cnt_d       = cnt_q;
        dout        = 1'b0;
        frame_start = 1'b0;

        unique case (state_q)
            P0: begin
                state_d     = P1;
                dout        = fr_q[2];
                frame_start = 1'b1;
            end
            P1: begin
                state_d = P2;
                dout    = fr_q[1];
            end
            P2: begin
                state_d = P0;
                dout    = fr_q[0];
                fr_d    = pop ? mem_q[rptr_q] : 3'b000;
            end
            default: state_d = P0;
        endcase

        if (push) begin
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= P0;
            fr_q     <= 3'b000;
            mem_q[0] <= 3'b000;
            mem_q[1] <= 3'b000;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            occ_q    <= 2'd0;
            rej_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            fr_q    <= fr_d;
            if (push) begin
                mem_q[wptr_q] <= in_if.in_data;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            rej_q  <= rej_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rej       = rej_q;
    assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench: one serializer with illegal-frame rejection, one without,
// sharing clock, reset and input stimulus.
module tb_frame_serializer;
    logic       clk;
    logic       rst;
    logic       v;
    logic [2:0] d;
    logic       da, fa, ja, db, fb, jb;
    logic [7:0] na, nb;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    frame_serializer_if ifa ();
    frame_serializer_if ifb ();

    assign ifa.in_data  = d;
    assign ifa.in_valid = v;
    assign ifb.in_data  = d;
    assign ifb.in_valid = v;

    frame_serializer #(.REJECT_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_if(ifa),
        .dout(da), .frame_start(fa), .rej(ja), .frame_cnt(na)
    );

    frame_serializer #(.REJECT_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_if(ifb),
        .dout(db), .frame_start(fb), .rej(jb), .frame_cnt(nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       r;
        logic       o;
        logic       f;
        logic       j;
        logic [7:0] n;
        logic       ob;
        logic       jb;
        logic [7:0] nb;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph == 2) ? 0 : ph + 1;
    endtask

    initial begin
        int e;
        //            v  d       r  o  f  j  n     ob jb nb
        tbl[0]  = '{1, 3'b101, 1, 0, 1, 0, 8'd0, 0, 0, 8'd0};
        tbl[1]  = '{0, 3'b000, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[2]  = '{0, 3'b000, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[3]  = '{0, 3'b000, 1, 1, 1, 0, 8'd1, 1, 0, 8'd1};
        tbl[4]  = '{0, 3'b000, 1, 0, 0, 0, 8'd1, 0, 0, 8'd1};
        tbl[5]  = '{0, 3'b000, 1, 1, 0, 0, 8'd1, 1, 0, 8'd1};
        tbl[6]  = '{1, 3'b100, 1, 0, 1, 0, 8'd1, 0, 0, 8'd1};
        tbl[7]  = '{1, 3'b010, 1, 0, 0, 0, 8'd1, 0, 0, 8'd1};
        tbl[8]  = '{1, 3'b011, 0, 0, 0, 0, 8'd1, 0, 0, 8'd1};
        tbl[9]  = '{1, 3'b011, 1, 1, 1, 0, 8'd2, 1, 0, 8'd2};
        tbl[10] = '{0, 3'b000, 0, 0, 0, 0, 8'd2, 0, 0, 8'd2};
        tbl[11] = '{0, 3'b000, 0, 0, 0, 0, 8'd2, 0, 0, 8'd2};
        tbl[12] = '{0, 3'b000, 1, 0, 1, 0, 8'd3, 0, 0, 8'd3};
        tbl[13] = '{0, 3'b000, 1, 1, 0, 0, 8'd3, 1, 0, 8'd3};
        tbl[14] = '{0, 3'b000, 1, 0, 0, 0, 8'd3, 0, 0, 8'd3};
        tbl[15] = '{0, 3'b000, 1, 0, 1, 0, 8'd4, 0, 0, 8'd4};
        tbl[16] = '{0, 3'b000, 1, 1, 0, 0, 8'd4, 1, 0, 8'd4};
        tbl[17] = '{0, 3'b000, 1, 1, 0, 0, 8'd4, 1, 0, 8'd4};
        tbl[18] = '{1, 3'b111, 1, 0, 1, 0, 8'd4, 0, 0, 8'd4};
        tbl[19] = '{0, 3'b000, 1, 0, 0, 1, 8'd4, 0, 0, 8'd4};
        tbl[20] = '{0, 3'b000, 1, 0, 0, 0, 8'd4, 0, 0, 8'd4};
        tbl[21] = '{0, 3'b000, 1, 0, 1, 0, 8'd4, 1, 0, 8'd5};
        tbl[22] = '{0, 3'b000, 1, 0, 0, 0, 8'd4, 1, 0, 8'd5};
        tbl[23] = '{1, 3'b001, 1, 0, 0, 0, 8'd4, 1, 0, 8'd5};

        rst = 1'b0;
        v   = 1'b0;
        d   = 3'b000;
        #2 rst = 1'b1;
        #1;
        chk("rst_dout", 0, {7'd0, da}, 8'd0);
        chk("rst_fs", 0, {7'd0, fa}, 8'd1);
        chk("rst_rdy", 0, {7'd0, ifa.in_ready}, 8'd1);
        chk("rst_cnt", 0, na, 8'd0);
        chk("rst_rej", 0, {7'd0, ja}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_fs", 0, {7'd0, fa}, 8'd1);
        rst = 1'b0;
        ph  = 0;

        for (int i = 0; i < 24; i++) begin
            chk("rdy_a", i, {7'd0, ifa.in_ready}, {7'd0, tbl[i].r});
            chk("rdy_b", i, {7'd0, ifb.in_ready}, {7'd0, tbl[i].r});
            chk("dout_a", i, {7'd0, da}, {7'd0, tbl[i].o});
            chk("fs_a", i, {7'd0, fa}, {7'd0, tbl[i].f});
            chk("rej_a", i, {7'd0, ja}, {7'd0, tbl[i].j});
            chk("cnt_a", i, na, tbl[i].n);
            chk("dout_b", i, {7'd0, db}, {7'd0, tbl[i].ob});
            chk("rej_b", i, {7'd0, jb}, {7'd0, tbl[i].jb});
            chk("cnt_b", i, nb, tbl[i].nb);
            v = tbl[i].v;
            d = tbl[i].d;
            step();
        end

        v = 1'b1;
        d = 3'b010;
        step();
        v = 1'b0;
        chk("full_rdy_a", 0, {7'd0, ifa.in_ready}, 8'd0);
        chk("full_phase_fs", 0, {7'd0, fa}, 8'd0);
        rst = 1'b1;
        #1;
        chk("mid_dout", 0, {7'd0, da}, 8'd0);
        chk("mid_fs", 0, {7'd0, fa}, 8'd1);
        chk("mid_rdy", 0, {7'd0, ifa.in_ready}, 8'd1);
        chk("mid_cnt_a", 0, na, 8'd0);
        chk("mid_cnt_b", 0, nb, 8'd0);
        #2 rst = 1'b0;
        ph = 0;
        for (int k = 0; k < 12; k++) begin
            chk("post_dout_a", k, {7'd0, da}, 8'd0);
            chk("post_dout_b", k, {7'd0, db}, 8'd0);
            chk("post_fs", k, {7'd0, fa}, (ph == 0) ? 8'd1 : 8'd0);
            chk("post_cnt", k, na, 8'd0);
            chk("post_rdy", k, {7'd0, ifa.in_ready}, 8'd1);
            step();
        end

        rst = 1'b1;
        #2 rst = 1'b0;
        ph = 0;
        v  = 1'b1;
        d  = 3'b101;
        e  = 0;
        for (int k = 0; k < 800; k++) begin
            if (k >= 3 && ph == 0 && e < 255) begin
                e++;
            end
            if (k >= 3) begin
                chk("sat_dout", k, {7'd0, da}, (ph == 1) ? 8'd0 : 8'd1);
            end
            chk("sat_cnt_a", k, na, e[7:0]);
            chk("sat_cnt_b", k, nb, e[7:0]);
            step();
        end
        chk("sat_final", 0, na, 8'd255);
        v = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
